// File: rtl/commit_marker_queue_if.sv
// Commit-side scan inputs and marker event stream of the commit marker queue.
// The queue attaches through the slave modport; the ROB/logger side uses master.
interface commit_marker_queue_if #(
  parameter int LANES = 2,
  parameter int SEQ_W = 32
);
  logic [LANES-1:0]    commit_valid;
  logic [LANES*32-1:0] commit_inst;
  logic                evt_valid;
  logic                evt_ready;
  logic [3:0]          evt_code;
  logic [1:0]          evt_lane;
  logic [SEQ_W-1:0]    evt_seq;

  modport master (
    output commit_valid, commit_inst, evt_ready,
    input  evt_valid, evt_code, evt_lane, evt_seq
  );

  modport slave (
    input  commit_valid, commit_inst, evt_ready,
    output evt_valid, evt_code, evt_lane, evt_seq
  );
endinterface

// File: rtl/commit_marker_queue.sv
// Detects phase-marker instructions (slti x0,x0,imm) on the commit lanes, queues them
// in commit order with lane/sequence tags, and tracks the open phase and nesting errors.
module commit_marker_queue #(
  parameter int LANES = 2,
  parameter int DEPTH = 8,
  parameter int SEQ_W = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  commit_marker_queue_if.slave   bus,
  output logic [2:0]             phase,
  output logic                   nest_err,
  output logic                   overflow,
  output logic [15:0]            drop_cnt
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TAL_W = CNT_W + 1;

  typedef struct packed {
    logic [3:0]       code;
    logic [1:0]       lane;
    logic [SEQ_W-1:0] seq;
  } entry_t;

  entry_t            mem_reg [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_reg, wr_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [SEQ_W-1:0]  seq_reg;
  logic [2:0]        phase_reg;
  logic              nest_err_reg;
  logic              overflow_reg;
  logic [15:0]       drop_cnt_reg;

  logic [LANES-1:0]  hit;
  logic [3:0]        code_w  [LANES];
  logic [TAL_W-1:0]  rank_c  [LANES];
  logic [LANES-1:0]  accept_c;
  entry_t            entry_c [LANES];

  logic              deq;
  logic [TAL_W-1:0]  free_c, n_hit_c, n_acc_c, drop_c;
  logic [16:0]       drop_sum_c;
  logic [15:0]       drop_cnt_next;
  logic [CNT_W-1:0]  count_next;
  logic [2:0]        phase_next;
  logic              nest_err_next;

  // Per-lane marker decode and the entry each lane would enqueue
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [31:0] inst;
      assign inst        = bus.commit_inst[32*gi +: 32];
      assign code_w[gi]  = inst[23:20];
      assign hit[gi]     = bus.commit_valid[gi] && (inst[19:0] == 20'h02013) &&
                           (inst[31:24] == 8'h00) && (inst[23:20] <= 4'hD);
      assign entry_c[gi] = '{code: code_w[gi],
                             lane: 2'(gi),
                             seq:  seq_reg + SEQ_W'(rank_c[gi])};
    end
  endgenerate

  assign deq = (count_reg != '0) && bus.evt_ready;

  // Rank each hit among this cycle's hits; the lowest-ranked ones take the free slots
  always_comb begin
    free_c  = TAL_W'(DEPTH) - TAL_W'(count_reg) + TAL_W'(deq);
    n_hit_c = '0;
    n_acc_c = '0;
    for (int i = 0; i < LANES; i++) begin
      rank_c[i]   = n_hit_c;
      accept_c[i] = hit[i] && (n_hit_c < free_c);
      n_hit_c     = n_hit_c + TAL_W'(hit[i]);
      n_acc_c     = n_acc_c + TAL_W'(accept_c[i]);
    end
    drop_c        = n_hit_c - n_acc_c;
    drop_sum_c    = {1'b0, drop_cnt_reg} + 17'(drop_c);
    drop_cnt_next = drop_sum_c[16] ? 16'hFFFF : drop_sum_c[15:0];
    count_next    = count_reg - CNT_W'(deq) + CNT_W'(n_acc_c);
  end

  // Phase tracker sees every hit, dropped or not, chained in lane order
  always_comb begin
    phase_next    = phase_reg;
    nest_err_next = nest_err_reg;
    for (int i = 0; i < LANES; i++) begin
      if (hit[i]) begin
        if (!code_w[i][0]) begin
          if (phase_next != 3'd7) nest_err_next = 1'b1;
          phase_next = code_w[i][3:1];
        end else begin
          if (phase_next != code_w[i][3:1]) nest_err_next = 1'b1;
          phase_next = 3'd7;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      seq_reg      <= '0;
      phase_reg    <= 3'd7;
      nest_err_reg <= 1'b0;
      overflow_reg <= 1'b0;
      drop_cnt_reg <= '0;
    end else begin
      rd_ptr_reg   <= rd_ptr_reg + PTR_W'(deq);
      wr_ptr_reg   <= wr_ptr_reg + PTR_W'(n_acc_c);
      count_reg    <= count_next;
      seq_reg      <= seq_reg + SEQ_W'(n_hit_c);
      phase_reg    <= phase_next;
      nest_err_reg <= nest_err_next;
      if (drop_c != '0) overflow_reg <= 1'b1;
      drop_cnt_reg <= drop_cnt_next;
    end
  end

  // Storage needs no reset: count_reg alone decides which slots are live
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) begin
        if (accept_c[i]) mem_reg[wr_ptr_reg + PTR_W'(rank_c[i])] <= entry_c[i];
      end
    end
  end

  assign bus.evt_valid = (count_reg != '0);
  assign bus.evt_code  = mem_reg[rd_ptr_reg].code;
  assign bus.evt_lane  = mem_reg[rd_ptr_reg].lane;
  assign bus.evt_seq   = mem_reg[rd_ptr_reg].seq;
  assign phase         = phase_reg;
  assign nest_err      = nest_err_reg;
  assign overflow      = overflow_reg;
  assign drop_cnt      = drop_cnt_reg;
endmodule

// File: tb/tb_commit_marker_queue.sv
// Directed-vector bench for commit_marker_queue with hand-computed expectations.
module tb_commit_marker_queue;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  phase;
  logic        nest_err;
  logic        overflow;
  logic [15:0] drop_cnt;
  int          n_vec = 0;
  int          n_err = 0;

  commit_marker_queue_if #(.LANES(2), .SEQ_W(32)) bus ();

  commit_marker_queue #(.LANES(2), .DEPTH(8), .SEQ_W(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .phase    (phase),
    .nest_err (nest_err),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [31:0] i0, input logic v1, input logic [31:0] i1);
    bus.commit_valid = {v1, v0};
    bus.commit_inst  = {i1, i0};
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    reset = 1'b1;
  endtask

  initial begin
    bus.evt_ready = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    tick();
    reset = 1'b1;
    check_eq("rst_valid", bus.evt_valid, 0);
    check_eq("rst_phase", phase, 7);
    check_eq("rst_nest", nest_err, 0);
    check_eq("rst_ovf", overflow, 0);
    check_eq("rst_drop", drop_cnt, 0);

    // single marker: START TEXE
    drive(1'b1, 32'h00402013, 1'b0, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    check_eq("single_valid", bus.evt_valid, 1);
    check_eq("single_code", bus.evt_code, 4);
    check_eq("single_lane", bus.evt_lane, 0);
    check_eq("single_seq", bus.evt_seq, 0);
    check_eq("single_phase", phase, 2);
    tick();
    check_eq("single_drained", bus.evt_valid, 0);

    // same-cycle START/END pair
    do_reset();
    drive(1'b1, 32'h00002013, 1'b1, 32'h00102013);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    check_eq("pair0_code", bus.evt_code, 0);
    check_eq("pair0_lane", bus.evt_lane, 0);
    check_eq("pair0_seq", bus.evt_seq, 0);
    check_eq("pair_phase", phase, 7);
    check_eq("pair_nest", nest_err, 0);
    tick();
    check_eq("pair1_valid", bus.evt_valid, 1);
    check_eq("pair1_code", bus.evt_code, 1);
    check_eq("pair1_lane", bus.evt_lane, 1);
    check_eq("pair1_seq", bus.evt_seq, 1);
    tick();
    check_eq("pair_drained", bus.evt_valid, 0);

    // non-markers and an invalid-lane marker
    do_reset();
    drive(1'b1, 32'h00002033, 1'b1, 32'h00e02013);
    tick();
    check_eq("nonmk_a_valid", bus.evt_valid, 0);
    drive(1'b1, 32'h00002093, 1'b0, 32'h00402013);
    tick();
    check_eq("nonmk_b_valid", bus.evt_valid, 0);
    check_eq("nonmk_phase", phase, 7);
    drive(1'b1, 32'h00002013, 1'b0, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    check_eq("nonmk_seq", bus.evt_seq, 0);
    check_eq("nonmk_valid", bus.evt_valid, 1);

    // backpressure then overflow: 10 markers into 8 slots
    do_reset();
    bus.evt_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 32'h00002013, 1'b1, 32'h00102013);
      tick();
      if (c == 3) check_eq("bp_no_ovf_yet", overflow, 0);
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    check_eq("bp_ovf", overflow, 1);
    check_eq("bp_drop", drop_cnt, 2);
    check_eq("bp_hold_seq", bus.evt_seq, 0);
    check_eq("bp_nest", nest_err, 0);
    bus.evt_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check_eq($sformatf("drain%0d_valid", k), bus.evt_valid, 1);
      check_eq($sformatf("drain%0d_seq", k), bus.evt_seq, 64'(k));
      check_eq($sformatf("drain%0d_lane", k), bus.evt_lane, 64'(k % 2));
      tick();
    end
    check_eq("drain_empty", bus.evt_valid, 0);
    drive(1'b0, 32'h0, 1'b1, 32'h00402013);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    check_eq("post_ovf_seq", bus.evt_seq, 10);
    check_eq("post_ovf_lane", bus.evt_lane, 1);
    check_eq("post_ovf_drop", drop_cnt, 2);

    // full FIFO with same-cycle dequeue accepts a new marker
    do_reset();
    bus.evt_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 32'h00002013, 1'b1, 32'h00102013);
      tick();
    end
    bus.evt_ready = 1'b1;
    drive(1'b1, 32'h00002013, 1'b0, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    check_eq("fulldq_ovf", overflow, 0);
    check_eq("fulldq_drop", drop_cnt, 0);
    for (int k = 1; k <= 8; k++) begin
      check_eq($sformatf("fulldq%0d_seq", k), bus.evt_seq, 64'(k));
      tick();
    end
    check_eq("fulldq_empty", bus.evt_valid, 0);

    // nesting errors, then reset flushes queued entries
    do_reset();
    bus.evt_ready = 1'b0;
    drive(1'b1, 32'h00802013, 1'b0, 32'h0);
    tick();
    check_eq("nest_start_phase", phase, 4);
    check_eq("nest_start_err", nest_err, 0);
    drive(1'b1, 32'h00c02013, 1'b0, 32'h0);
    tick();
    check_eq("nest_dbl_phase", phase, 6);
    check_eq("nest_dbl_err", nest_err, 1);
    drive(1'b1, 32'h00302013, 1'b0, 32'h0);
    tick();
    check_eq("nest_end_phase", phase, 7);
    check_eq("nest_queued", bus.evt_valid, 1);
    do_reset();
    check_eq("flush_valid", bus.evt_valid, 0);
    check_eq("flush_nest", nest_err, 0);
    check_eq("flush_ovf", overflow, 0);
    check_eq("flush_drop", drop_cnt, 0);
    check_eq("flush_phase", phase, 7);
    bus.evt_ready = 1'b1;
    drive(1'b1, 32'h00002013, 1'b0, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    check_eq("flush_seq", bus.evt_seq, 0);
    check_eq("flush_new_valid", bus.evt_valid, 1);
    tick();
    check_eq("flush_no_survivor", bus.evt_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
